// File: rtl/mult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Number of shift-add steps for a given operand width and digit size.
    function automatic int unsigned iter_count(int unsigned width, int unsigned bpc);
        return width / bpc;
    endfunction

    // Magnitude of a 32-bit two's-complement value; -2^31 maps to 2^31 unsigned.
    function automatic logic [31:0] abs_val(logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product generator: BPC-bit multiplier digit times WIDTH-bit multiplicand.
// Kept as its own block so the digit network can be replaced without touching the datapath.
module mult_pp_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic [BPC-1:0]       digit,
    input  logic [WIDTH-1:0]     mcand,
    output logic [WIDTH+BPC-1:0] pp
);

    // Sum of the multiplicand shifted by each set digit bit.
    always_comb begin
        pp = '0;
        for (int i = 0; i < BPC; i++) begin
            if (digit[i]) begin
                pp = pp + ((WIDTH + BPC)'(mcand) << i);
            end
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier, BPC multiplier bits per cycle, unsigned or signed operands.
// Signed operands are reduced to magnitudes on capture; the sign is reapplied to the final sum.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned ITER = iter_count(WIDTH, BPC);
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (WIDTH < 2 || WIDTH > 32 || (BPC != 1 && BPC != 2) || (WIDTH % BPC) != 0) begin : g_bad_params
        $error("seq_mult_param: illegal WIDTH/BPC combination");
    end

    state_e                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplr;
    logic [2*WIDTH-1:0]     acc;
    logic                   neg;

    logic [31:0]            a_abs;
    logic [31:0]            b_abs;
    logic [WIDTH-1:0]       a_cap;
    logic [WIDTH-1:0]       b_cap;
    logic [WIDTH+BPC-1:0]   pp;
    logic [2*WIDTH+BPC-1:0] sum;
    logic [2*WIDTH-1:0]     acc_step;

    // Operand conditioning: magnitudes in signed mode, raw bits otherwise.
    always_comb begin
        a_abs = abs_val(32'($signed(A)));
        b_abs = abs_val(32'($signed(B)));
        a_cap = signed_mode ? a_abs[WIDTH-1:0] : A;
        b_cap = signed_mode ? b_abs[WIDTH-1:0] : B;
    end

    mult_pp_gen #(
        .WIDTH(WIDTH),
        .BPC  (BPC)
    ) u_pp_gen (
        .digit(mplr[BPC-1:0]),
        .mcand(mcand),
        .pp   (pp)
    );

    // Add the digit product into the top half, then shift right by one digit.
    // The bits shifted out are always zero, so the step is exact.
    always_comb begin
        sum      = {{BPC{1'b0}}, acc} + {pp, {WIDTH{1'b0}}};
        acc_step = sum[2*WIDTH+BPC-1:BPC];
    end

    logic unused_sum_lo;
    assign unused_sum_lo = ^sum[BPC-1:0];

    if (WIDTH < 32) begin : g_abs_hi
        logic unused_abs_hi;
        assign unused_abs_hi = ^{a_abs[31:WIDTH], b_abs[31:WIDTH]};
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            P         <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a_cap;
                        mplr     <= b_cap;
                        neg      <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    acc  <= acc_step;
                    mplr <= mplr >> BPC;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        // Negating zero yields zero, so no negative-zero result.
                        P         <= neg ? -acc_step : acc_step;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
